// File: rtl/autobaud_ctrl.sv
// Auto-baud controller: measures a 0x55 sync character and drives the oversampling tick.
// Optional RX majority glitch filter is enabled by defining AUTOBAUD_GLITCH_FILTER_EN.
module autobaud_ctrl #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned DEFAULT_BAUD   = 19200,
    parameter int unsigned OVERSAMPLING   = 16,
    parameter int unsigned NB_DIV         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx,
    input  logic              i_start,
    output logic              o_tick,
    output logic [NB_DIV-1:0] o_divisor,
    output logic              o_busy,
    output logic              o_locked,
    output logic              o_error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned SHIFT = $clog2(8 * OVERSAMPLING);
    localparam int unsigned DW    = (CNT_W >= NB_DIV) ? CNT_W + 1 : NB_DIV + 1;

    localparam logic [NB_DIV-1:0] DEFAULT_DIV  = NB_DIV'(CLK_FREQ / DEFAULT_BAUD / OVERSAMPLING);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0]     DIV_MAX      = DW'((64'd1 << NB_DIV) - 64'd1);
    localparam logic [DW-1:0]     ROUND_HALF   = DW'(4 * OVERSAMPLING);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, COMPUTE} state_t;

    logic rx_meta, rx_sync, rx_cur, rx_prev, rx_fall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

`ifdef AUTOBAUD_GLITCH_FILTER_EN
    logic [1:0] rx_hist;
    logic       rx_filt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_hist <= '1;
            rx_filt <= 1'b1;
        end else begin
            rx_hist <= {rx_hist[0], rx_sync};
            rx_filt <= (rx_sync & rx_hist[0]) | (rx_sync & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
        end
    end

    assign rx_cur = rx_filt;
`else
    assign rx_cur = rx_sync;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) rx_prev <= 1'b1;
        else         rx_prev <= rx_cur;
    end

    assign rx_fall = rx_prev & ~rx_cur;

    state_t            state, state_next;
    logic [CNT_W-1:0]  meas_cnt, meas_cnt_next;
    logic [2:0]        edge_cnt, edge_cnt_next;
    logic              busy_next, locked_next, error_next, div_load;
    logic [NB_DIV-1:0] divisor_next;
    logic [DW-1:0]     div_full;
    logic              div_ok, timeout;

    // Full-width rounding divide so out-of-range results are caught before truncation.
    assign div_full = (DW'(meas_cnt) + ROUND_HALF) >> SHIFT;
    assign div_ok   = (div_full >= DW'(2)) && (div_full <= DIV_MAX);
    assign timeout  = (meas_cnt == TIMEOUT_LAST);

    always_comb begin
        state_next    = state;
        meas_cnt_next = meas_cnt;
        edge_cnt_next = edge_cnt;
        busy_next     = o_busy;
        locked_next   = o_locked;
        error_next    = o_error;
        divisor_next  = o_divisor;
        div_load      = 1'b0;
        if (i_start) begin
            state_next    = WAIT_EDGE;
            meas_cnt_next = '0;
            edge_cnt_next = '0;
            error_next    = 1'b0;
            busy_next     = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                WAIT_EDGE: begin
                    if (timeout) begin
                        error_next = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else if (rx_fall) begin
                        meas_cnt_next = '0;
                        edge_cnt_next = 3'd1;
                        state_next    = MEASURE;
                    end else begin
                        meas_cnt_next = meas_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (timeout) begin
                        error_next = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        // Counting through the 5th edge cycle leaves exactly 8 bit times.
                        meas_cnt_next = meas_cnt + 1'b1;
                        if (rx_fall) begin
                            edge_cnt_next = edge_cnt + 1'b1;
                            if (edge_cnt == 3'd4) state_next = COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                    if (div_ok) begin
                        divisor_next = div_full[NB_DIV-1:0];
                        locked_next  = 1'b1;
                        div_load     = 1'b1;
                    end else begin
                        error_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            meas_cnt  <= '0;
            edge_cnt  <= '0;
            o_busy    <= 1'b0;
            o_locked  <= 1'b0;
            o_error   <= 1'b0;
            o_divisor <= DEFAULT_DIV;
        end else begin
            state     <= state_next;
            meas_cnt  <= meas_cnt_next;
            edge_cnt  <= edge_cnt_next;
            o_busy    <= busy_next;
            o_locked  <= locked_next;
            o_error   <= error_next;
            o_divisor <= divisor_next;
        end
    end

    logic [NB_DIV-1:0] tick_cnt;

    assign o_tick = (tick_cnt == o_divisor - NB_DIV'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset)       tick_cnt <= '0;
        else if (div_load) tick_cnt <= '0;
        else if (o_tick)   tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + 1'b1;
    end

endmodule

// File: doc/autobaud_ctrl.md
# autobaud_ctrl

Auto-baud controller and runtime-programmable oversampling tick source for the UART path. On request it measures an incoming 0x55 sync character on the RX line and computes the clock-cycles-per-tick divisor. It then drives the oversampling tick from that divisor, so UART RX/TX consume `o_tick` exactly as they would from a fixed generator. Until the first successful calibration it ticks at a compile-time default rate.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `DEFAULT_BAUD`, 19200, baud rate used after reset.
- `OVERSAMPLING`, 16, ticks per bit; must be a power of two.
- `NB_DIV`, 16, divisor width.
- `TIMEOUT_CYCLES`, 50_000_000, abort limit for a calibration attempt.

- `i_clk`, in, 1, system clock.
- `i_reset`, in, 1, synchronous, active-high reset.
- `i_rx`, in, 1, asynchronous serial line; idle high.
- `i_start`, in, 1, single-cycle pulse that begins calibration.
- `o_tick`, out, 1, one-cycle tick every `o_divisor` cycles.
- `o_divisor`, out, NB_DIV, current cycles-per-tick value.
- `o_busy`, out, 1, calibration in progress.
- `o_locked`, out, 1, at least one calibration has succeeded since reset.
- `o_error`, out, 1, the last calibration attempt failed.

## Operation
- RX path: 2-flop synchronizer, then a registered previous sample. A falling edge is `prev==1 && cur==0`.
- States are IDLE, WAIT_EDGE, MEASURE and COMPUTE.
- IDLE: waits for `i_start`.
- `i_start` in any state:
  - clears the cycle counter, edge count and `o_error`;
  - asserts `o_busy`;
  - moves to WAIT_EDGE.
  - A restart mid-measurement is legal.
- WAIT_EDGE: the first falling edge (start bit) clears the counter, sets edge count to 1 and moves to MEASURE.
- MEASURE: the counter increments every cycle. Each falling edge increments edge count. The 5th falling edge (d7 of 0x55) moves to COMPUTE, with the counter then holding exactly 8 bit times.
- COMPUTE: `div = (count + 4*OVERSAMPLING) >> log2(8*OVERSAMPLING)`, i.e. count/128 rounded to nearest for OVERSAMPLING=16.
  - If `2 <= div <= 2^NB_DIV-1`: load `o_divisor`, set `o_locked`.
  - Otherwise: set `o_error` and keep the old divisor.
  - Either way, go to IDLE.
- Timeout: if the counter reaches `TIMEOUT_CYCLES-1` in WAIT_EDGE or MEASURE, set `o_error`, go to IDLE, and leave the divisor unchanged.
- Tick generator:
  - Counter from 0 to `o_divisor-1`.
  - `o_tick = (tick_cnt == o_divisor-1)`, combinational from registers.
  - Loading a new divisor clears `tick_cnt` on the same edge.
- Internal width rules:
  - Measurement counter width is `clogb2(TIMEOUT_CYCLES)`.
  - Divisor arithmetic is done at full counter width before the range check, so no truncation occurs before the comparison.

## Timing
- Reset values:
  - `o_divisor = CLK_FREQ/DEFAULT_BAUD/OVERSAMPLING`, integer truncation (162 for defaults);
  - tick counter 0, `o_tick` 0;
  - `o_busy` 0, `o_locked` 0, `o_error` 0;
  - state IDLE.
- Reset mid-calibration aborts it and restores all of the above. Reset has priority over `i_start`.
- `o_busy` rises on the edge after `i_start` is sampled. It falls on the edge that ends COMPUTE or the timeout cycle.
- `o_divisor`, `o_locked` and `o_error` update on that same edge.
- RX-to-edge-detect latency is 3 cycles. It is identical for all edges, so it cancels in the measurement.
- First tick after a divisor load: `o_tick` is high `new_div-1` cycles after the load edge, then every `new_div` cycles.
- A falling edge coincident with `i_start` is ignored; `i_start` wins.

## Configuration
- `AUTOBAUD_GLITCH_FILTER_EN`:
  - When defined, a 3-sample majority filter is inserted after the synchronizer. This adds 2 cycles of RX latency and rejects 1-cycle glitches.
  - When undefined, the synchronizer output feeds edge detection directly, and single-cycle pulses count as edges.

## Test plan
Bench uses `TIMEOUT_CYCLES=200_000`.

- Reset:
  - Stimulus: assert `i_reset` 4 cycles, then release.
  - Required: `o_divisor=162`, `o_tick` period 162 cycles, `o_locked=0`, `o_error=0`, `o_busy=0`.
- Calibration at 5208 cycles/bit:
  - Stimulus: `i_start`, then 0x55 at a bit period of 5208 cycles.
  - Required: `o_divisor=326`, `o_locked=1`, `o_error=0`. Subsequent `o_tick` period is 326, with the first tick 325 cycles after the load edge.
- Calibration at 434 cycles/bit:
  - Stimulus: `i_start`, then 0x55 at a bit period of 434 cycles.
  - Required: `o_divisor=27`.
- Too-fast line (16 cycles/bit):
  - Stimulus: 0x55 at a bit period of 16 cycles.
  - Required: div=1, `o_error=1`, `o_divisor` unchanged, `o_locked` unchanged.
- Timeout:
  - Stimulus: `i_start` with the line held high for 200_000 cycles.
  - Required: `o_error=1`, `o_busy=0` at cycle 200_000 after start.
- Restart and glitch:
  - Stimulus: second `i_start` during MEASURE, followed by a clean 0x55 at 5208 cycles/bit.
  - Required: result 326.
  - With `AUTOBAUD_GLITCH_FILTER_EN` defined, a 1-cycle low glitch injected mid-bit does not change the result.
